// File: rtl/jt51_pm_pkg.sv
// Shared constants, stage payloads and the PMS depth table for the PM apply path.
package jt51_pm_pkg;

  localparam int unsigned PM_W          = 8;
  localparam int unsigned PMS_W         = 3;
  localparam int unsigned KC_W          = 7;
  localparam int unsigned KF_W          = 6;
  localparam int unsigned DELTA_W       = 9;
  localparam int unsigned LIN_W         = 14;
  localparam int unsigned SUM_W         = 13;
  localparam int unsigned SUM_EXT_W     = 15;
  localparam int unsigned SEMIS_W       = 7;
  localparam int unsigned NOTE_W        = 4;

  localparam int unsigned LIN_MAX       = 6143;
  localparam int unsigned SEMI_STEPS    = 64;
  localparam int unsigned OCT_STEPS     = 768;
  localparam int unsigned NOTES_PER_OCT = 12;

  // Depth table: right-shift amounts for pms 1..5, left-shift amounts for pms 6..7
  localparam int unsigned PMS1_SHR = 5;
  localparam int unsigned PMS2_SHR = 4;
  localparam int unsigned PMS3_SHR = 3;
  localparam int unsigned PMS4_SHR = 2;
  localparam int unsigned PMS5_SHR = 1;
  localparam int unsigned PMS6_SHL = 1;
  localparam int unsigned PMS7_SHL = 2;

  // Stage 1 -> stage 2 payload: scaled depth, its sign, linear pitch, frame marker
  typedef struct packed {
    logic [DELTA_W-1:0] delta;
    logic               neg;
    logic [LIN_W-1:0]   lin;
    logic               zero;
  } pm_s1_t;

  // Stage 2 -> stage 3 payload: clamped linear pitch and frame marker
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             zero;
  } pm_s2_t;

  // Scale the PM magnitude by the channel sensitivity
  function automatic logic [DELTA_W-1:0] pms_scale(input logic [PMS_W-1:0] pms,
                                                   input logic [PM_W-2:0]  mag);
    logic [DELTA_W-1:0] mx;
    mx = DELTA_W'(mag);
    case (pms)
      3'd1:    pms_scale = mx >> PMS1_SHR;
      3'd2:    pms_scale = mx >> PMS2_SHR;
      3'd3:    pms_scale = mx >> PMS3_SHR;
      3'd4:    pms_scale = mx >> PMS4_SHR;
      3'd5:    pms_scale = mx >> PMS5_SHR;
      3'd6:    pms_scale = mx << PMS6_SHL;
      3'd7:    pms_scale = mx << PMS7_SHL;
      default: pms_scale = '0;
    endcase
  endfunction

endpackage

// File: rtl/jt51_pm_lin2kc.sv
// Combinational converter from linear 1/64-semitone pitch back to YM2151 KC/KF.
module jt51_pm_lin2kc
  import jt51_pm_pkg::*;
(
  input  logic [SUM_W-1:0] lin,
  output logic [KC_W-1:0]  kc_c,
  output logic [KF_W-1:0]  kf_c
);

  localparam logic [SEMIS_W-1:0] OCT4 = SEMIS_W'(4 * NOTES_PER_OCT);
  localparam logic [SEMIS_W-1:0] OCT2 = SEMIS_W'(2 * NOTES_PER_OCT);
  localparam logic [SEMIS_W-1:0] OCT1 = SEMIS_W'(NOTES_PER_OCT);

  logic [SEMIS_W-1:0] semis;
  logic [SEMIS_W-1:0] rem2;
  logic [SEMIS_W-1:0] rem1;
  logic [SEMIS_W-1:0] rem0;
  logic [2:0]         oct;
  logic [NOTE_W-1:0]  note;
  logic [NOTE_W-1:0]  skip;

  // Divide semitones by 12 with a restoring compare/subtract chain, then re-insert the unused codes
  always_comb begin
    semis = lin[SUM_W-1:KF_W];
    oct   = '0;
    rem2  = semis;
    if (semis >= OCT4) begin
      oct[2] = 1'b1;
      rem2   = semis - OCT4;
    end
    rem1 = rem2;
    if (rem2 >= OCT2) begin
      oct[1] = 1'b1;
      rem1   = rem2 - OCT2;
    end
    rem0 = rem1;
    if (rem1 >= OCT1) begin
      oct[0] = 1'b1;
      rem0   = rem1 - OCT1;
    end
    note = NOTE_W'(rem0);
    if (note >= 4'd9)      skip = 4'd3;
    else if (note >= 4'd6) skip = 4'd2;
    else if (note >= 4'd3) skip = 4'd1;
    else                   skip = 4'd0;
    kc_c = {oct, note + skip};
    kf_c = lin[KF_W-1:0];
  end

endmodule

// File: rtl/jt51_pm_apply.sv
// Applies the latched LFO PM value, scaled by PMS, to each slot's KC/KF over a 3-stage pipeline.
module jt51_pm_apply
  import jt51_pm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              zero,
  input  logic [PM_W-1:0]   pm_u,
  input  logic [PMS_W-1:0]  pms,
  input  logic [KC_W-1:0]   kc,
  input  logic [KF_W-1:0]   kf,
  output logic [KC_W-1:0]   kc_mod,
  output logic [KF_W-1:0]   kf_mod,
  output logic              zero_out
);

  localparam logic signed [SUM_EXT_W-1:0] LIN_MAX_S = SUM_EXT_W'(LIN_MAX);

  logic [PM_W-1:0]             pm_lat;
  logic [PM_W-1:0]             pm_cur_c;
  logic [NOTE_W-1:0]           note_c;
  pm_s1_t                      s1_c;
  pm_s1_t                      s1_q;
  logic signed [SUM_EXT_W-1:0] sum_c;
  pm_s2_t                      s2_c;
  pm_s2_t                      s2_q;
  logic [KC_W-1:0]             kc_c;
  logic [KF_W-1:0]             kf_c;

  // The frame's first slot sees the value being latched this cycle
  always_comb begin
    pm_cur_c = zero ? pm_u : pm_lat;
  end

  // Hold the LFO PM value for a whole 32-slot frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pm_lat <= '0;
    else if (clk_en && zero)  pm_lat <= pm_u;
  end

  // Stage 1: depth scaling and KC/KF linearisation (invalid note codes fold onto the next note)
  always_comb begin
    s1_c       = '0;
    note_c     = kc[3:0] - {2'b00, kc[3:2]};
    s1_c.delta = pms_scale(pms, pm_cur_c[PM_W-2:0]);
    s1_c.neg   = pm_cur_c[PM_W-1];
    s1_c.lin   = LIN_W'(kc[KC_W-1:NOTE_W]) * LIN_W'(OCT_STEPS)
               + LIN_W'(note_c) * LIN_W'(SEMI_STEPS)
               + LIN_W'(kf);
    s1_c.zero  = zero;
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         s1_q <= '0;
    else if (clk_en) s1_q <= s1_c;
  end

  // Stage 2: signed offset by the PM delta, clamped to the 8-octave range
  always_comb begin
    s2_c = '0;
    if (s1_q.neg)
      sum_c = $signed({1'b0, s1_q.lin}) - $signed(SUM_EXT_W'(s1_q.delta));
    else
      sum_c = $signed({1'b0, s1_q.lin}) + $signed(SUM_EXT_W'(s1_q.delta));
    if (sum_c < 0)              s2_c.sum = '0;
    else if (sum_c > LIN_MAX_S) s2_c.sum = SUM_W'(LIN_MAX);
    else                        s2_c.sum = SUM_W'($unsigned(sum_c));
    s2_c.zero = s1_q.zero;
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         s2_q <= '0;
    else if (clk_en) s2_q <= s2_c;
  end

  jt51_pm_lin2kc u_lin2kc (
    .lin  (s2_q.sum),
    .kc_c (kc_c),
    .kf_c (kf_c)
  );

  // Stage 3 register: reconverted KC/KF and aligned frame marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kc_mod   <= '0;
      kf_mod   <= '0;
      zero_out <= 1'b0;
    end else if (clk_en) begin
      kc_mod   <= kc_c;
      kf_mod   <= kf_c;
      zero_out <= s2_q.zero;
    end
  end

endmodule
